// File: rtl/seg_disp_src.sv
// seg_disp_src
//   Source selector / formatter feeding the 8-digit seven-segment driver.
//   Picks a CPU debug word (PC, instruction, register-file entry, data-memory
//   word, ALU result) or a fixed text banner, and registers it together with
//   the display mode. Also owns the regfile/dmem scan index, stepped by a
//   debounced push-button or by an auto-scan timer.
//
// Ports
//   clk, rstn         : clock, asynchronous active-low reset
//   sw_src[2:0]       : 0 PC, 1 instr, 2 regfile, 3 dmem, 4 ALU, 5 banner, 6/7 blank
//   sw_auto           : enables auto-scan while sw_src is 2 or 3
//   btn_step          : raw asynchronous step button (active high)
//   pc, instr, alu_y  : debug words
//   rf_rdata/rf_raddr : regfile debug read port (data combinational from addr)
//   dm_rdata/dm_raddr : dmem debug read port (data combinational from addr)
//   idx[4:0]          : current scan index
//   disp_data[63:0]   : driver data (hex: low 32 bits; raw: 8 active-low bytes)
//   disp_mode         : 0 hex, 1 raw segment bytes
module seg_disp_src #(
  parameter int unsigned DEB_W  = 20,
  parameter int unsigned SCAN_W = 26
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  sw_src,
  input  logic        sw_auto,
  input  logic        btn_step,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] alu_y,
  input  logic [31:0] rf_rdata,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] dm_rdata,
  output logic [3:0]  dm_raddr,
  output logic [4:0]  idx,
  output logic [63:0] disp_data,
  output logic        disp_mode
);

  typedef enum logic [2:0] {
    SRC_PC     = 3'd0,
    SRC_INSTR  = 3'd1,
    SRC_RF     = 3'd2,
    SRC_DM     = 3'd3,
    SRC_ALU    = 3'd4,
    SRC_BANNER = 3'd5,
    SRC_BLANK6 = 3'd6,
    SRC_BLANK7 = 3'd7
  } src_e;

  // "PIPE" on the four leftmost digits (active-low segment bytes), rest blank
  localparam logic [63:0] BANNER = 64'h8CF98C86_FFFFFFFF;

  src_e              src;
  logic              btn_s1, btn_s2;
  logic              deb_lvl;
  logic [DEB_W-1:0]  deb_cnt, deb_cnt_inc;
  logic              deb_accept;
  logic              btn_pulse;
  logic [SCAN_W-1:0] scan_cnt;
  logic              scan_run;
  logic              auto_pulse;
  logic              step;
  logic [2:0]        src_prev;
  logic              src_chg;
  logic [4:0]        idx_q, idx_nxt;
  logic [63:0]       data_nxt;
  logic              mode_nxt;
  logic [63:0]       disp_data_q;
  logic              disp_mode_q;

  assign src = src_e'(sw_src);

  // The level is accepted on the same edge at which the counter would reach
  // all-ones, so 2^DEB_W-1 consecutive differing cycles flip it. The rising
  // pulse is generated from that acceptance so idx advances on the same edge.
  assign deb_cnt_inc = deb_cnt + 1'b1;
  assign deb_accept  = (btn_s2 != deb_lvl) && (&deb_cnt_inc);
  assign btn_pulse   = deb_accept && btn_s2;

  assign scan_run   = sw_auto && ((src == SRC_RF) || (src == SRC_DM));
  assign auto_pulse = scan_run && (&scan_cnt);
  assign step       = btn_pulse || auto_pulse;
  assign src_chg    = (sw_src != src_prev);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      deb_lvl <= 1'b0;
      deb_cnt <= '0;
    end else begin
      btn_s1 <= btn_step;
      btn_s2 <= btn_s1;
      if (btn_s2 == deb_lvl) begin
        deb_cnt <= '0;
      end else if (deb_accept) begin
        deb_lvl <= btn_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scan_cnt <= '0;
    end else if (scan_run) begin
      scan_cnt <= scan_cnt + 1'b1;
    end else begin
      scan_cnt <= '0;
    end
  end

  always_comb begin
    idx_nxt = idx_q;
    if (src_chg) begin
      idx_nxt = '0;
    end else if (step && (src == SRC_RF)) begin
      idx_nxt = idx_q + 5'd1;
    end else if (step && (src == SRC_DM)) begin
      idx_nxt = {1'b0, idx_q[3:0] + 4'd1};
    end
  end

  always_comb begin
    data_nxt = '0;
    mode_nxt = 1'b0;
    unique case (src)
      SRC_PC:     data_nxt = {32'h0, pc};
      SRC_INSTR:  data_nxt = {32'h0, instr};
      SRC_RF:     data_nxt = {32'h0, rf_rdata};
      SRC_DM:     data_nxt = {32'h0, dm_rdata};
      SRC_ALU:    data_nxt = {32'h0, alu_y};
      SRC_BANNER: begin
        data_nxt = BANNER;
        mode_nxt = 1'b1;
      end
      SRC_BLANK6, SRC_BLANK7: begin
        data_nxt = '1;
        mode_nxt = 1'b1;
      end
      default: begin
        data_nxt = '1;
        mode_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      src_prev    <= '0;
      idx_q       <= '0;
      disp_data_q <= '0;
      disp_mode_q <= 1'b0;
    end else begin
      src_prev    <= sw_src;
      idx_q       <= idx_nxt;
      disp_data_q <= data_nxt;
      disp_mode_q <= mode_nxt;
    end
  end

  assign idx       = idx_q;
  assign rf_raddr  = idx_q;
  assign dm_raddr  = idx_q[3:0];
  assign disp_data = disp_data_q;
  assign disp_mode = disp_mode_q;

endmodule
